ws2812_strip_ctrl: RTL and testbench

WS2812_STRIP_CTRL -- requirements
Module: ws2812_strip_ctrl

---
 rtl/ws2812_strip_ctrl_pkg.sv | 26 ++
 rtl/ws2812_strip_ctrl_if.sv | 25 ++
 rtl/ws2812_bit_gen.sv | 51 +++++
 rtl/ws2812_strip_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ws2812_strip_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_strip_ctrl_pkg.sv
// rtl/ws2812_strip_ctrl_pkg.sv - shared constants, FSM state type and helpers for the WS2812 strip controller
// Holds the register word offsets, the CTRL bit positions, the frame FSM
// states and a counter-width helper used by the controller and bit generator.
package ws2812_strip_ctrl_pkg;

    localparam logic [11:0] CTRL_OFFSET    = 12'h100;
    localparam logic [11:0] STATUS_OFFSET  = 12'h104;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_AUTO_BIT  = 1;

    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } state_t;

    // Width of a counter that must reach limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/ws2812_strip_ctrl_if.sv
// rtl/ws2812_strip_ctrl_if.sv - APB3 register bus bundle for the WS2812 strip controller
// Ports: PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0] (master -> slave);
//        PRDATA[31:0], PREADY, PSLVERR (slave -> master).
interface ws2812_strip_ctrl_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/ws2812_bit_gen.sv
// rtl/ws2812_bit_gen.sv - one WS2812 bit cell: high for T1H/T0H cycles, low for the rest of CLK_PER_BIT
// Ports: clk, rst_n (async active-low); start + bit_val begin a new bit cell;
//        led is the serial waveform; done pulses in the last cycle of a cell.
// A start in the same cycle as done chains the next bit with no idle gap.
module ws2812_bit_gen
    import ws2812_strip_ctrl_pkg::*;
#(
    parameter int CLK_PER_BIT = 125,
    parameter int T1H         = 80,
    parameter int T0H         = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic led,
    output logic done
);

    localparam int CW  = cnt_width(CLK_PER_BIT);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_PER_BIT - 1);
    localparam logic [CW:0]   HIGH_1   = CW1'(T1H);
    localparam logic [CW:0]   HIGH_0   = CW1'(T0H);

    logic          active_q;
    logic          bit_q;
    logic [CW-1:0] cnt_q;

    assign done = active_q && (cnt_q == LAST_CNT);
    // Extra compare bit keeps a high time equal to CLK_PER_BIT representable.
    assign led  = active_q && ({1'b0, cnt_q} < (bit_q ? HIGH_1 : HIGH_0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            bit_q    <= bit_val;
            cnt_q    <= '0;
        end else if (done) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (active_q) begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_strip_ctrl.sv
// rtl/ws2812_strip_ctrl.sv - APB3-programmed WS2812 LED strip frame transmitter
// Ports: PCLK, PRESERN (async active-low); apb (APB3 slave: PIXEL[i] at word i,
//        CTRL at 0x100, STATUS at 0x104); LED serial data output.
// A LOAD cycle snapshots every PIXEL register into a shadow frame, so bus
// writes during a frame only affect the next one.
module ws2812_strip_ctrl
    import ws2812_strip_ctrl_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int CLK_PER_BIT  = 125,
    parameter int T1H          = 80,
    parameter int T0H          = 40,
    parameter int RESET_CYCLES = 6000
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    ws2812_strip_ctrl_if.slave apb,
    output logic               LED
);

    localparam int PIX_W = cnt_width(NUM_LEDS);
    localparam int LAT_W = cnt_width(RESET_CYCLES);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);
    localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_PIXEL - 1);

    state_t state_q;
    state_t state_d;

    logic             auto_q;
    logic [23:0]      pixel_q  [NUM_LEDS];
    logic [23:0]      shadow_q [NUM_LEDS];
    logic [PIX_W-1:0] pix_idx_q;
    logic [PIX_W-1:0] nxt_pix;
    logic [4:0]       bit_cnt_q;
    logic [4:0]       nxt_bit;
    logic [LAT_W-1:0] lat_cnt_q;

    logic [9:0]  word_idx;
    logic        pix_sel;
    logic        ctrl_sel;
    logic        status_sel;
    logic        wr_en;
    logic        start_wr;
    logic [31:0] rdata;

    logic bg_start;
    logic bg_bit;
    logic bg_done;
    logic last_bit;

    logic unused_apb;
    assign unused_apb = ^{apb.PADDR[31:12], apb.PADDR[1:0], apb.PWDATA[31:24]};

    // ---------------- register decode ----------------
    assign word_idx   = apb.PADDR[11:2];
    assign pix_sel    = word_idx < 10'(NUM_LEDS);
    assign ctrl_sel   = word_idx == CTRL_OFFSET[11:2];
    assign status_sel = word_idx == STATUS_OFFSET[11:2];
    assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign start_wr   = wr_en & ctrl_sel & apb.PWDATA[CTRL_START_BIT];

    always_comb begin
        rdata = '0;
        if (pix_sel) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (word_idx == 10'(i)) rdata = {8'h00, pixel_q[i]};
            end
        end else if (ctrl_sel) begin
            rdata[CTRL_AUTO_BIT] = auto_q;
        end else if (status_sel) begin
            rdata[0]   = (state_q != ST_IDLE);
            rdata[7:1] = 7'(pix_idx_q);
        end
    end

    assign apb.PRDATA  = apb.PSEL ? rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~(pix_sel | ctrl_sel | status_sel);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            auto_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) pixel_q[i] <= '0;
        end else if (wr_en) begin
            if (ctrl_sel) auto_q <= apb.PWDATA[CTRL_AUTO_BIT];
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (pix_sel && word_idx == 10'(i)) pixel_q[i] <= apb.PWDATA[23:0];
            end
        end
    end

    // ---------------- frame sequencing ----------------
    // Position of the bit that follows the one currently on the wire.
    always_comb begin
        if (bit_cnt_q == LAST_BIT) begin
            nxt_bit = '0;
            nxt_pix = pix_idx_q + 1'b1;
        end else begin
            nxt_bit = bit_cnt_q + 1'b1;
            nxt_pix = pix_idx_q;
        end
    end

    assign last_bit = (pix_idx_q == LAST_PIX) && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        bg_start = 1'b0;
        bg_bit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_wr || auto_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // The shadow is written on this edge, so the first bit comes
                // from the live register it is being copied from.
                bg_start = 1'b1;
                bg_bit   = pixel_q[0][LAST_BIT];
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (bg_done) begin
                    if (last_bit) begin
                        state_d = ST_LATCH;
                    end else begin
                        bg_start = 1'b1;
                        bg_bit   = shadow_q[nxt_pix][LAST_BIT - nxt_bit];
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) state_d = auto_q ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            pix_idx_q <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) shadow_q[i] <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    for (int i = 0; i < NUM_LEDS; i++) shadow_q[i] <= pixel_q[i];
                    pix_idx_q <= '0;
                    bit_cnt_q <= '0;
                end
                ST_SEND: begin
                    lat_cnt_q <= '0;
                    if (bg_done && !last_bit) begin
                        pix_idx_q <= nxt_pix;
                        bit_cnt_q <= nxt_bit;
                    end
                end
                ST_LATCH: begin
                    lat_cnt_q <= lat_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    ws2812_bit_gen #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .T1H         (T1H),
        .T0H         (T0H)
    ) u_bit_gen (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .start   (bg_start),
        .bit_val (bg_bit),
        .led     (LED),
        .done    (bg_done)
    );

endmodule

// File: tb/tb_ws2812_strip_ctrl.sv
// tb/tb_ws2812_strip_ctrl.sv - directed self-checking bench for ws2812_strip_ctrl
module tb_ws2812_strip_ctrl;

    localparam int NUM_LEDS     = 2;
    localparam int CLK_PER_BIT  = 125;
    localparam int T1H          = 80;
    localparam int T0H          = 40;
    localparam int RESET_CYCLES = 6000;
    localparam int NBITS        = 24 * NUM_LEDS;
    localparam int LOW_CAP      = 6200;
    localparam int FRAME_CYCLES = 1 + NBITS * CLK_PER_BIT + RESET_CYCLES;

    localparam logic [31:0] A_PIX0   = 32'h000;
    localparam logic [31:0] A_PIX1   = 32'h004;
    localparam logic [31:0] A_PIX2   = 32'h008;
    localparam logic [31:0] A_CTRL   = 32'h100;
    localparam logic [31:0] A_STATUS = 32'h104;
    localparam logic [31:0] A_BAD    = 32'h200;

    logic PCLK = 1'b0;
    logic PRESERN = 1'b0;
    logic LED;

    ws2812_strip_ctrl_if apb();

    ws2812_strip_ctrl #(
        .NUM_LEDS     (NUM_LEDS),
        .CLK_PER_BIT  (CLK_PER_BIT),
        .T1H          (T1H),
        .T0H          (T0H),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .apb     (apb),
        .LED     (LED)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    int               hi_len [NBITS];
    int               lo_len [NBITS];
    logic [NBITS-1:0] obs_bits;
    int               n_long;
    int               n_short;
    int               n_bad_period;
    int               total_len;
    bit               frame_seen;

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PENABLE = 1'b0;
        apb.PADDR = addr; apb.PWDATA = data;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0;
        apb.PADDR = addr;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        #1;
        data = apb.PRDATA;
        err  = apb.PSLVERR;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    // Records high/low run lengths of one frame, sampled on falling edges.
    task automatic measure_frame(input int wait_max);
        int n;
        frame_seen = 1'b0;
        obs_bits = '0;
        n_long = 0; n_short = 0; n_bad_period = 0; total_len = 0;
        for (int b = 0; b < NBITS; b++) begin hi_len[b] = 0; lo_len[b] = 0; end
        n = 0;
        while (LED !== 1'b1 && n < wait_max) begin @(negedge PCLK); n++; end
        if (LED !== 1'b1) return;
        frame_seen = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            n = 0;
            while (LED === 1'b1 && n < 200) begin @(negedge PCLK); n++; end
            hi_len[b] = n;
            n = 0;
            while (LED === 1'b0 && n < LOW_CAP) begin @(negedge PCLK); n++; end
            lo_len[b] = n;
            if (n == LOW_CAP) break;
        end
        for (int b = 0; b < NBITS; b++) begin
            obs_bits[NBITS-1-b] = (hi_len[b] == T1H);
            if (hi_len[b] == T1H) n_long++;
            if (hi_len[b] == T0H) n_short++;
            if (b < NBITS - 1 && hi_len[b] + lo_len[b] != CLK_PER_BIT) n_bad_period++;
            total_len += hi_len[b] + lo_len[b];
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        int          highs;
        PRESERN = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++; if (LED !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", LED); end
        checks++; if (apb.PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b expected 1", apb.PREADY); end
        apb_read(A_STATUS, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
        apb_read(A_CTRL, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        apb_read(A_PIX0, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pix0: got %h expected 0", d); end
        PRESERN = 1'b1;
        highs = 0;
        repeat (300) begin @(negedge PCLK); if (LED !== 1'b0) highs++; end
        checks++; if (highs != 0) begin errors++; $display("FAIL reset_idle_led: got %0d high cycles expected 0", highs); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic        e;
        int          highs;
        apb_write(A_PIX0, 32'hAB123456);
        apb_read(A_PIX0, d, e);
        checks++; if (d !== 32'h00123456) begin errors++; $display("FAIL pix0_mask: got %h expected 00123456", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL pix0_slverr: got %b expected 0", e); end
        apb_write(A_PIX1, 32'h00ABCDEF);
        apb_read(A_PIX1, d, e);
        checks++; if (d !== 32'h00ABCDEF) begin errors++; $display("FAIL pix1_rw: got %h expected 00abcdef", d); end
        apb_read(A_BAD, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_rd_slverr: got %b expected 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_rd_data: got %h expected 0", d); end
        apb_read(A_PIX2, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL pix2_slverr: got %b expected 1", e); end
        apb_write(A_BAD, 32'hFFFFFFFF);
        apb_read(A_PIX0, d, e);
        checks++; if (d !== 32'h00123456) begin errors++; $display("FAIL bad_wr_pix0: got %h expected 00123456", d); end
        apb_read(A_CTRL, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_wr_ctrl: got %h expected 0", d); end
        highs = 0;
        repeat (50) begin @(negedge PCLK); if (LED !== 1'b0) highs++; end
        checks++; if (highs != 0) begin errors++; $display("FAIL bad_wr_led: got %0d high cycles expected 0", highs); end
    endtask

    task automatic test_frame();
        logic [31:0] d;
        logic        e;
        apb_write(A_PIX0, 32'h00FF0000);
        apb_write(A_PIX1, 32'h00000001);
        apb_write(A_CTRL, 32'h1);
        measure_frame(20);
        checks++; if (frame_seen !== 1'b1) begin errors++; $display("FAIL frame_start: got %b expected 1", frame_seen); end
        checks++; if (n_long != 9) begin errors++; $display("FAIL frame_long_pulses: got %0d expected 9", n_long); end
        checks++; if (n_short != 39) begin errors++; $display("FAIL frame_short_pulses: got %0d expected 39", n_short); end
        checks++; if (obs_bits !== 48'hFF0000_000001) begin errors++; $display("FAIL frame_bits: got %h expected ff0000000001", obs_bits); end
        checks++; if (n_bad_period != 0) begin errors++; $display("FAIL frame_period: got %0d bad bits expected 0", n_bad_period); end
        checks++; if (lo_len[NBITS-1] != LOW_CAP) begin errors++; $display("FAIL frame_tail: got %0d expected %0d", lo_len[NBITS-1], LOW_CAP); end
        apb_read(A_STATUS, d, e);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b expected 0", d[0]); end
        apb_read(A_CTRL, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL frame_ctrl_rd: got %h expected 0", d); end
    endtask

    task automatic test_midframe_write();
        logic [31:0] d;
        logic [31:0] st;
        logic        e;
        apb_write(A_CTRL, 32'h1);
        fork
            measure_frame(20);
            begin
                repeat (1000) @(negedge PCLK);
                apb_write(A_PIX0, 32'h00123456);
                apb_read(A_STATUS, st, e);
                apb_write(A_CTRL, 32'h1);
            end
        join
        checks++; if (st[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", st[0]); end
        checks++; if (obs_bits !== 48'hFF0000_000001) begin errors++; $display("FAIL mid_frozen_bits: got %h expected ff0000000001", obs_bits); end
        checks++; if (n_bad_period != 0) begin errors++; $display("FAIL mid_period: got %0d bad bits expected 0", n_bad_period); end
        checks++; if (total_len != (NBITS - 1) * CLK_PER_BIT + T1H + LOW_CAP) begin
            errors++; $display("FAIL mid_frame_len: got %0d expected %0d", total_len, (NBITS - 1) * CLK_PER_BIT + T1H + LOW_CAP);
        end
        apb_read(A_PIX0, d, e);
        checks++; if (d !== 32'h00123456) begin errors++; $display("FAIL mid_pix0_rd: got %h expected 00123456", d); end
        apb_write(A_CTRL, 32'h1);
        measure_frame(20);
        checks++; if (obs_bits !== 48'h123456_000001) begin errors++; $display("FAIL next_frame_bits: got %h expected 123456000001", obs_bits); end
        checks++; if (lo_len[NBITS-1] != LOW_CAP) begin errors++; $display("FAIL next_frame_tail: got %0d expected %0d", lo_len[NBITS-1], LOW_CAP); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] c;
        logic        e;
        apb_write(A_CTRL, 32'h3);
        measure_frame(20);
        checks++; if (obs_bits !== 48'h123456_000001) begin errors++; $display("FAIL auto_f1_bits: got %h expected 123456000001", obs_bits); end
        checks++; if (lo_len[NBITS-1] != CLK_PER_BIT - T1H + RESET_CYCLES + 1) begin
            errors++; $display("FAIL auto_gap: got %0d expected %0d", lo_len[NBITS-1], CLK_PER_BIT - T1H + RESET_CYCLES + 1);
        end
        checks++; if (total_len != FRAME_CYCLES) begin errors++; $display("FAIL auto_frame_len: got %0d expected %0d", total_len, FRAME_CYCLES); end
        fork
            measure_frame(5);
            begin
                repeat (3000) @(negedge PCLK);
                apb_read(A_CTRL, c, e);
                apb_write(A_CTRL, 32'h0);
            end
        join
        checks++; if (c !== 32'h2) begin errors++; $display("FAIL auto_ctrl_rd: got %h expected 2", c); end
        checks++; if (frame_seen !== 1'b1) begin errors++; $display("FAIL auto_f2_start: got %b expected 1", frame_seen); end
        checks++; if (obs_bits !== 48'h123456_000001) begin errors++; $display("FAIL auto_f2_bits: got %h expected 123456000001", obs_bits); end
        checks++; if (lo_len[NBITS-1] != LOW_CAP) begin errors++; $display("FAIL auto_stop_tail: got %0d expected %0d", lo_len[NBITS-1], LOW_CAP); end
        apb_read(A_STATUS, d, e);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL auto_busy_end: got %b expected 0", d[0]); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic        e;
        int          n;
        int          highs;
        apb_write(A_CTRL, 32'h1);
        repeat (300) @(negedge PCLK);
        n = 0;
        while (LED !== 1'b1 && n < 200) begin @(negedge PCLK); n++; end
        checks++; if (LED !== 1'b1) begin errors++; $display("FAIL rst_mid_high: got %b expected 1", LED); end
        PRESERN = 1'b0;
        #1;
        checks++; if (LED !== 1'b0) begin errors++; $display("FAIL rst_mid_led: got %b expected 0", LED); end
        @(negedge PCLK);
        apb_read(A_STATUS, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got %h expected 0", d); end
        apb_read(A_PIX0, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_pix0: got %h expected 0", d); end
        PRESERN = 1'b1;
        highs = 0;
        repeat (300) begin @(negedge PCLK); if (LED !== 1'b0) highs++; end
        checks++; if (highs != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d high cycles expected 0", highs); end
        apb_read(A_STATUS, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status2: got %h expected 0", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        @(negedge PCLK);
        test_reset();
        test_regs();
        test_frame();
        test_midframe_write();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
